// File: rtl/alu_core.sv
// Registered 32-bit integer ALU with zero and signed-overflow flags; 1-cycle latency.
// No backpressure: a new operation is accepted on every rising edge.
module alu_core (
   input  logic        clk,
   input  logic        reset,
   input  logic [31:0] A,
   input  logic [31:0] B,
   input  logic [2:0]  ALUControl,
   output logic [31:0] R,
   output logic        zero,
   output logic        ovf
);

   typedef enum logic [2:0] {
      OP_AND  = 3'b000,
      OP_OR   = 3'b001,
      OP_ADD  = 3'b010,
      OP_XOR  = 3'b011,
      OP_NOR  = 3'b100,
      OP_SLTU = 3'b101,
      OP_SUB  = 3'b110,
      OP_SLT  = 3'b111
   } alu_op_t;

   logic [31:0] sum;
   logic [31:0] diff;
   logic [31:0] next_r;
   logic        next_ovf;

   assign sum  = A + B;
   assign diff = A - B;

   // SLT uses a true signed compare so it stays correct when A-B overflows.
   always_comb begin
      next_r   = 32'h0;
      next_ovf = 1'b0;
      case (alu_op_t'(ALUControl))
         OP_AND:  next_r = A & B;
         OP_OR:   next_r = A | B;
         OP_ADD: begin
            next_r   = sum;
            next_ovf = (A[31] == B[31]) && (sum[31] != A[31]);
         end
         OP_XOR:  next_r = A ^ B;
         OP_NOR:  next_r = ~(A | B);
         OP_SLTU: next_r = {31'b0, (A < B)};
         OP_SUB: begin
            next_r   = diff;
            next_ovf = (A[31] != B[31]) && (diff[31] != A[31]);
         end
         OP_SLT:  next_r = {31'b0, ($signed(A) < $signed(B))};
         default: next_r = 32'h0;
      endcase
   end

   always_ff @(posedge clk) begin
      if (reset) begin
         R    <= 32'h0;
         zero <= 1'b1;
         ovf  <= 1'b0;
      end else begin
         R    <= next_r;
         zero <= (next_r == 32'h0);
         ovf  <= next_ovf;
      end
   end

endmodule

// File: tb/tb_alu_core.sv
// Directed vector table plus random run with a reference model for alu_core.
module tb_alu_core;

   logic        clk = 1'b0;
   logic        reset;
   logic [31:0] A;
   logic [31:0] B;
   logic [2:0]  ALUControl;
   logic [31:0] R;
   logic        zero;
   logic        ovf;

   int checks = 0;
   int errors = 0;

   alu_core dut (
      .clk(clk),
      .reset(reset),
      .A(A),
      .B(B),
      .ALUControl(ALUControl),
      .R(R),
      .zero(zero),
      .ovf(ovf)
   );

   always #5 clk = ~clk;

   typedef struct {
      string       name;
      logic [31:0] a;
      logic [31:0] b;
      logic [2:0]  op;
      logic [31:0] r;
      logic        z;
      logic        o;
   } vec_t;

   task automatic check(input string name, input logic [31:0] er, input logic ez, input logic eo);
      checks++;
      if (R !== er || zero !== ez || ovf !== eo) begin
         errors++;
         $display("FAIL %s: got R=%h zero=%b ovf=%b, expected R=%h zero=%b ovf=%b",
                  name, R, zero, ovf, er, ez, eo);
      end
   endtask

   // Reference model built on wide signed arithmetic rather than sign-bit rules.
   task automatic model(input logic [31:0] a, input logic [31:0] b, input logic [2:0] op,
                        output logic [31:0] r, output logic z, output logic o);
      longint sa, sb, s;
      sa = longint'($signed(a));
      sb = longint'($signed(b));
      o  = 1'b0;
      case (op)
         3'd0: r = a & b;
         3'd1: r = a | b;
         3'd2: begin
            s = sa + sb;
            r = s[31:0];
            o = (s > 64'sd2147483647) || (s < -64'sd2147483648);
         end
         3'd3: r = a ^ b;
         3'd4: r = ~(a | b);
         3'd5: r = (a < b) ? 32'd1 : 32'd0;
         3'd6: begin
            s = sa - sb;
            r = s[31:0];
            o = (s > 64'sd2147483647) || (s < -64'sd2147483648);
         end
         default: r = (sa < sb) ? 32'd1 : 32'd0;
      endcase
      z = (r == 32'h0);
   endtask

   vec_t vecs[14];

   initial begin
      logic [31:0] er;
      logic        ez, eo;

      vecs[0]  = '{"and",      32'hF0F0_00FF, 32'h0FF0_0F0F, 3'b000, 32'h00F0_000F, 1'b0, 1'b0};
      vecs[1]  = '{"or",       32'hF0F0_00FF, 32'h0FF0_0F0F, 3'b001, 32'hFFF0_0FFF, 1'b0, 1'b0};
      vecs[2]  = '{"xor",      32'hF0F0_00FF, 32'h0FF0_0F0F, 3'b011, 32'hFF00_0FF0, 1'b0, 1'b0};
      vecs[3]  = '{"nor",      32'hF0F0_00FF, 32'h0FF0_0F0F, 3'b100, 32'h000F_F000, 1'b0, 1'b0};
      vecs[4]  = '{"add_ovf",  32'h7FFF_FFFF, 32'h0000_0001, 3'b010, 32'h8000_0000, 1'b0, 1'b1};
      vecs[5]  = '{"add_wrap", 32'hFFFF_FFFF, 32'h0000_0001, 3'b010, 32'h0000_0000, 1'b1, 1'b0};
      vecs[6]  = '{"sub_ovf",  32'h8000_0000, 32'h0000_0001, 3'b110, 32'h7FFF_FFFF, 1'b0, 1'b1};
      vecs[7]  = '{"sub_zero", 32'h0000_0007, 32'h0000_0007, 3'b110, 32'h0000_0000, 1'b1, 1'b0};
      vecs[8]  = '{"slt_neg",  32'hFFFF_FFFF, 32'h0000_0001, 3'b111, 32'h0000_0001, 1'b0, 1'b0};
      vecs[9]  = '{"sltu_neg", 32'hFFFF_FFFF, 32'h0000_0001, 3'b101, 32'h0000_0000, 1'b1, 1'b0};
      vecs[10] = '{"slt_ovf",  32'h8000_0000, 32'h7FFF_FFFF, 3'b111, 32'h0000_0001, 1'b0, 1'b0};
      vecs[11] = '{"slt_eq",   32'h1234_5678, 32'h1234_5678, 3'b111, 32'h0000_0000, 1'b1, 1'b0};
      vecs[12] = '{"sub_neg",  32'h0000_0003, 32'h0000_0005, 3'b110, 32'hFFFF_FFFE, 1'b0, 1'b0};
      vecs[13] = '{"sltu_lt",  32'h0000_0003, 32'h8000_0000, 3'b101, 32'h0000_0001, 1'b0, 1'b0};

      // Reset takes priority over the ADD present at the edge.
      reset = 1'b1;
      A = 32'd5;
      B = 32'd3;
      ALUControl = 3'b010;
      @(posedge clk);
      #1 check("reset", 32'h0, 1'b1, 1'b0);
      @(negedge clk);
      reset = 1'b0;
      @(posedge clk);
      #1 check("post_reset_add", 32'd8, 1'b0, 1'b0);

      for (int i = 0; i < 14; i++) begin
         @(negedge clk);
         A = vecs[i].a;
         B = vecs[i].b;
         ALUControl = vecs[i].op;
         @(posedge clk);
         #1 check(vecs[i].name, vecs[i].r, vecs[i].z, vecs[i].o);
      end
      er = vecs[13].r;
      ez = vecs[13].z;
      eo = vecs[13].o;

      // Random run: inputs change on falling edges, outputs checked after each
      // rising edge and again just before the next input change.
      void'($urandom(32'd20240601));
      for (int i = 0; i < 1000; i++) begin
         @(negedge clk);
         check("hold", er, ez, eo);
         A = $urandom();
         B = ($urandom_range(0, 3) == 0) ? A : $urandom();
         ALUControl = 3'($urandom_range(0, 7));
         reset = (i == 500);
         if (reset) begin
            er = 32'h0;
            ez = 1'b1;
            eo = 1'b0;
         end else begin
            model(A, B, ALUControl, er, ez, eo);
         end
         @(posedge clk);
         #1 check(reset ? "mid_reset" : (i == 501 ? "after_reset" : "random"), er, ez, eo);
      end
      @(negedge clk);
      reset = 1'b0;

      $display("CHECKS %0d ERRORS %0d", checks, errors);
      $finish;
   end

endmodule
